sram_responder: RTL

Bus responder (slave) for the Z80 computer's shared 8-bit system bus. It accepts cs/we/addr/data requests from whichever master currently owns the bus (CPU or UART master). It runs a timed access on an external asynchronous SRAM and returns read data with a single-cycle ack. It decodes its own address window, counts programmable strobe cycles, and tolerates the master dropping cs mid-access.

---
 rtl/sram_responder_pkg.sv | 26 ++
 rtl/sram_responder.sv | 118 +++++++++++
 2 files changed

// File: rtl/sram_responder_pkg.sv
// Shared definitions for the Z80 system-bus SRAM responder: FSM encoding,
// bus address map and default strobe lengths.
package sram_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_ACK,
        ST_RECOVER
    } state_t;

    localparam logic [15:0] SRAM_BASE       = 16'h8000;
    localparam logic [15:0] UART_SLAVE_BASE = 16'h0100;

    localparam int unsigned RD_CYCLES_DEF = 2;
    localparam int unsigned WR_CYCLES_DEF = 3;

    // Counter width able to hold the longer strobe's CYCLES-1 load value.
    function automatic int unsigned cnt_width(input int unsigned rd, input int unsigned wr);
        int unsigned mx;
        mx = (rd > wr) ? rd : wr;
        return (mx > 1) ? $clog2(mx) : 1;
    endfunction

endpackage

// File: rtl/sram_responder.sv
// Bus responder that runs timed accesses on an asynchronous SRAM and returns
// a one-cycle ack; every output is a register fed from next-state decode.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 15,
    parameter logic [15:0] BASE_ADDR = SRAM_BASE,
    parameter int unsigned RD_CYCLES = RD_CYCLES_DEF,
    parameter int unsigned WR_CYCLES = WR_CYCLES_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [15:0]       i_addr,
    input  logic [7:0]        i_dat,
    output logic [7:0]        o_dat,
    input  logic              i_we,
    input  logic              i_cs,
    output logic              o_ack,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [7:0]        o_sram_dq,
    output logic              o_sram_dq_oe,
    input  logic [7:0]        i_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n
);

    localparam int unsigned CNT_W = cnt_width(RD_CYCLES, WR_CYCLES);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              we_q, we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        dq_nxt, dat_nxt;
    logic              hit;
    logic              ce_n_nxt, oe_n_nxt, we_n_nxt, dq_oe_nxt, ack_nxt;

    assign hit = i_cs && (i_addr[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we_nxt    = we_q;
        addr_nxt  = o_sram_addr;
        dq_nxt    = o_sram_dq;
        dat_nxt   = o_dat;
        unique case (state)
            ST_IDLE: begin
                if (hit) begin
                    state_nxt = ST_SETUP;
                    we_nxt    = i_we;
                    addr_nxt  = i_addr[ADDR_W-1:0];
                    dq_nxt    = i_dat;
                end
            end
            ST_SETUP: begin
                if (!i_cs) begin
                    state_nxt = ST_RECOVER;
                end else begin
                    cnt_nxt   = we_q ? CNT_W'(WR_CYCLES - 1) : CNT_W'(RD_CYCLES - 1);
                    state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                // An abort outranks completion so o_dat stays untouched.
                if (!i_cs) begin
                    state_nxt = ST_RECOVER;
                end else if (cnt == '0) begin
                    state_nxt = ST_ACK;
                    if (!we_q) dat_nxt = i_sram_dq;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_ACK:     state_nxt = ST_RECOVER;
            ST_RECOVER: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase

        // Strobes are decoded from the state being entered, then registered.
        ce_n_nxt  = !(state_nxt inside {ST_SETUP, ST_STROBE, ST_ACK});
        oe_n_nxt  = !(!we_nxt && (state_nxt inside {ST_SETUP, ST_STROBE}));
        we_n_nxt  = !(we_nxt && (state_nxt == ST_STROBE));
        dq_oe_nxt = we_nxt && (state_nxt inside {ST_SETUP, ST_STROBE, ST_ACK});
        ack_nxt   = (state_nxt == ST_ACK);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_dq    <= '0;
            o_dat        <= '0;
            o_ack        <= 1'b0;
            o_sram_dq_oe <= 1'b0;
            o_sram_ce_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            we_q         <= we_nxt;
            o_sram_addr  <= addr_nxt;
            o_sram_dq    <= dq_nxt;
            o_dat        <= dat_nxt;
            o_ack        <= ack_nxt;
            o_sram_dq_oe <= dq_oe_nxt;
            o_sram_ce_n  <= ce_n_nxt;
            o_sram_oe_n  <= oe_n_nxt;
            o_sram_we_n  <= we_n_nxt;
        end
    end

endmodule
